// File: rtl/mem_rd_sched.sv
// Read scheduler for the shared word-addressed read port.
// Arbitrates burst reads from the command decoder (requester 0) and the
// inventory backscatter (requester 1), sequences addresses and the read
// strobe, runs a sensor-sample handshake before any read of TEMP_ADDR and
// returns words tagged with the owning requester.
//
// Handshake summary: REQx is a level held by the requester until its one-cycle
// GNTx pulse; ADDRx/LENx are captured on the grant edge and ignored afterwards.
// Returned words have no ready: RVALID is asserted for exactly one cycle per
// word and the consumer must take RDATA/RID/RLAST in that cycle. The sensor
// gets a one-cycle TSTART and answers with the TRDY level.
module mem_rd_sched #(
  parameter int          AW        = 6,
  parameter int          DW        = 16,
  parameter int          RD_LAT    = 1,
  parameter int unsigned TEMP_ADDR = 7,
  parameter int          TMO       = 15
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          REQ0,
  input  logic [AW-1:0] ADDR0,
  input  logic [5:0]    LEN0,
  input  logic          REQ1,
  input  logic [AW-1:0] ADDR1,
  input  logic [5:0]    LEN1,
  output logic          GNT0,
  output logic          GNT1,
  output logic [AW-1:0] A,
  output logic          RD_EN,
  input  logic [DW-1:0] DATA_RD,
  output logic          TSTART,
  input  logic          TRDY,
  output logic [DW-1:0] RDATA,
  output logic          RVALID,
  output logic          RID,
  output logic          RLAST,
  output logic          DONE,
  output logic          BUSY,
  output logic          TERR,
  output logic [1:0]    o_dbg_state
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_TSAMP = 2'd1;
  localparam logic [1:0] S_ISSUE = 2'd2;
  localparam logic [1:0] S_WAIT  = 2'd3;

  localparam int TCW = $clog2(TMO + 1);

  localparam logic [AW-1:0] TEMP_A = AW'(TEMP_ADDR);

  logic [1:0]     r_state;
  logic           r_last;      // requester served by the most recent grant
  logic [5:0]     r_rem;       // words still to be returned
  logic [1:0]     r_wcnt;      // cycles spent waiting for read data
  logic [TCW-1:0] r_tcnt;      // cycles since TSTART
  logic [AW-1:0]  r_addr;      // current word address, drives A

  logic           w_req;
  logic           w_win;
  logic [AW-1:0]  w_start_addr;
  logic [5:0]     w_start_len;
  logic [AW-1:0]  w_next_addr;

  assign A           = r_addr;
  assign o_dbg_state = r_state;

  // Round-robin winner selection and next-address arithmetic.
  always_comb begin
    w_req = REQ0 | REQ1;
    w_win = 1'b0;
    if (REQ0 && REQ1) begin
      w_win = ~r_last;
    end else if (REQ1) begin
      w_win = 1'b1;
    end
    w_start_addr = w_win ? ADDR1 : ADDR0;
    w_start_len  = w_win ? LEN1 : LEN0;
    w_next_addr  = r_addr + 1'b1;
  end

  // Burst FSM; every output is a register updated here. Entering ISSUE on a
  // fresh address at TEMP_ADDR withholds RD_EN and detours through TSAMP; the
  // TSAMP->ISSUE transition is the "sample taken" mark, and it is forgotten
  // as soon as the address moves on, so each visit samples again.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= S_IDLE;
      r_last  <= 1'b1;
      r_rem   <= '0;
      r_wcnt  <= '0;
      r_tcnt  <= '0;
      r_addr  <= '0;
      GNT0    <= 1'b0;
      GNT1    <= 1'b0;
      RD_EN   <= 1'b0;
      TSTART  <= 1'b0;
      RDATA   <= '0;
      RVALID  <= 1'b0;
      RID     <= 1'b0;
      RLAST   <= 1'b0;
      DONE    <= 1'b0;
      BUSY    <= 1'b0;
      TERR    <= 1'b0;
    end else begin
      GNT0   <= 1'b0;
      GNT1   <= 1'b0;
      RD_EN  <= 1'b0;
      TSTART <= 1'b0;
      RVALID <= 1'b0;
      RLAST  <= 1'b0;
      DONE   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_req) begin
            GNT0   <= ~w_win;
            GNT1   <= w_win;
            BUSY   <= 1'b1;
            TERR   <= 1'b0;
            RID    <= w_win;
            r_last <= w_win;
            r_addr <= w_start_addr;
            r_rem  <= w_start_len;
            if (w_start_len == 6'd0) begin
              // zero-length burst: skip straight to the DONE decision
              r_state <= S_WAIT;
            end else begin
              r_state <= S_ISSUE;
              RD_EN   <= (w_start_addr != TEMP_A);
            end
          end
        end
        S_ISSUE: begin
          if (RD_EN) begin
            r_state <= S_WAIT;
            r_wcnt  <= 2'd1;
          end else begin
            r_state <= S_TSAMP;
            TSTART  <= 1'b1;
            r_tcnt  <= TCW'(1);
          end
        end
        S_TSAMP: begin
          // TRDY is ignored in the TSTART cycle so a level left over from an
          // earlier sample cannot satisfy this one.
          if (!TSTART && TRDY) begin
            r_state <= S_ISSUE;
            RD_EN   <= 1'b1;
          end else if (r_tcnt == TCW'(TMO)) begin
            r_state <= S_ISSUE;
            RD_EN   <= 1'b1;
            TERR    <= 1'b1;
          end else begin
            r_tcnt <= r_tcnt + 1'b1;
          end
        end
        default: begin
          if (r_rem == 6'd0) begin
            DONE    <= 1'b1;
            BUSY    <= 1'b0;
            r_state <= S_IDLE;
          end else if (r_wcnt == 2'(RD_LAT)) begin
            RDATA  <= DATA_RD;
            RVALID <= 1'b1;
            r_rem  <= r_rem - 1'b1;
            if (r_rem == 6'd1) begin
              RLAST   <= 1'b1;
              DONE    <= 1'b1;
              BUSY    <= 1'b0;
              r_state <= S_IDLE;
            end else begin
              r_addr  <= w_next_addr;
              RD_EN   <= (w_next_addr != TEMP_A);
              r_state <= S_ISSUE;
            end
          end else begin
            r_wcnt <= r_wcnt + 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_rd_sched.sv
// Directed bench for mem_rd_sched: per-cycle traces of the outputs are packed
// into bit masks indexed by cycle (cycle 1 = first cycle after the edge that
// samples the request) and compared with hand-derived values.
module tb_mem_rd_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0 = 1'b0, req1 = 1'b0;
  logic [5:0]  addr0 = '0, addr1 = '0, len0 = '0, len1 = '0;
  logic        gnt0, gnt1, rd_en, tstart, trdy, rvalid, rid, rlast, done, busy, terr;
  logic [5:0]  a;
  logic [15:0] data_rd = '0;
  logic [15:0] rdata;
  logic [1:0]  dbg_state;

  logic [15:0] tval = 16'h0000;
  int          sens_dly = 0;
  int          scnt = 0;
  logic        hold = 1'b0;

  int n_total = 0;
  int n_bad   = 0;

  logic [63:0] m_gnt0, m_gnt1, m_rd_en, m_tstart, m_rvalid, m_rlast, m_done, m_busy, m_terr;
  logic [5:0]  a_at [64];
  logic [15:0] d_at [64];
  logic        rid_at [64];

  // clock / reset
  always #5 clk = ~clk;

  mem_rd_sched dut (
    .CLK(clk), .RST(rst),
    .REQ0(req0), .ADDR0(addr0), .LEN0(len0),
    .REQ1(req1), .ADDR1(addr1), .LEN1(len1),
    .GNT0(gnt0), .GNT1(gnt1), .A(a), .RD_EN(rd_en), .DATA_RD(data_rd),
    .TSTART(tstart), .TRDY(trdy), .RDATA(rdata), .RVALID(rvalid), .RID(rid),
    .RLAST(rlast), .DONE(done), .BUSY(busy), .TERR(terr), .o_dbg_state(dbg_state)
  );

  // memory with one cycle of read latency; word 7 is the sensor value
  always @(posedge clk) begin
    if (rd_en) data_rd <= (a == 6'd7) ? tval : (16'hA000 | {10'd0, a});
  end

  // sensor: TRDY rises sens_dly cycles after TSTART (never when sens_dly is 0)
  always @(posedge clk) begin
    if (rst) scnt <= 0;
    else if (tstart) scnt <= 1;
    else if (scnt != 0 && scnt < 60) scnt <= scnt + 1;
  end
  assign trdy = (sens_dly != 0) && (scnt >= sens_dly);

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0; hold = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", {gnt0, gnt1, a, rd_en, tstart, rdata, rvalid, rid, rlast, done, busy, terr}, 64'd0);
    rst = 1'b0;
    m_gnt0 = '0; m_gnt1 = '0; m_rd_en = '0; m_tstart = '0; m_rvalid = '0;
    m_rlast = '0; m_done = '0; m_busy = '0; m_terr = '0;
  endtask

  // advance one cycle and record the outputs of cycle c
  task automatic tick(input int c);
    @(posedge clk);
    #1;
    m_gnt0[c] = gnt0;   m_gnt1[c] = gnt1;   m_rd_en[c] = rd_en;
    m_tstart[c] = tstart; m_rvalid[c] = rvalid; m_rlast[c] = rlast;
    m_done[c] = done;   m_busy[c] = busy;   m_terr[c] = terr;
    a_at[c] = a; d_at[c] = rdata; rid_at[c] = rid;
    if (gnt0 && !hold) req0 = 1'b0;
    if (gnt1 && !hold) req1 = 1'b0;
  endtask

  initial begin
    // single burst
    do_reset();
    addr0 = 6'd2; len0 = 6'd3; req0 = 1'b1;
    for (int c = 1; c <= 10; c++) tick(c);
    chk("t1_gnt0", m_gnt0, 64'h2);
    chk("t1_rd_en", m_rd_en, 64'h2A);
    chk("t1_rvalid", m_rvalid, 64'hA8);
    chk("t1_rdata", {d_at[3], d_at[5], d_at[7]}, {16'hA002, 16'hA003, 16'hA004});
    chk("t1_rlast", m_rlast, 64'h80);
    chk("t1_done", m_done, 64'h80);
    chk("t1_busy", m_busy, 64'h7E);
    chk("t1_rid", rid_at[7], 64'd0);

    // simultaneous requests, both held
    do_reset();
    hold = 1'b1;
    addr0 = 6'd10; len0 = 6'd1; addr1 = 6'd20; len1 = 6'd1;
    req0 = 1'b1; req1 = 1'b1;
    for (int c = 1; c <= 12; c++) tick(c);
    hold = 1'b0; req0 = 1'b0; req1 = 1'b0;
    chk("t2_gnt0", m_gnt0, 64'h82);
    chk("t2_gnt1", m_gnt1, 64'h410);
    chk("t2_done", m_done, 64'h1248);
    chk("t2_rid", {rid_at[3], rid_at[6], rid_at[9], rid_at[12]}, 64'b0101);
    chk("t2_rdata", {d_at[3], d_at[6]}, {16'hA00A, 16'hA014});

    // temperature word
    do_reset();
    sens_dly = 4; tval = 16'h1234;
    addr1 = 6'd6; len1 = 6'd3; req1 = 1'b1;
    for (int c = 1; c <= 15; c++) tick(c);
    chk("t3_tstart", m_tstart, 64'h10);
    chk("t3_a_at_tstart", a_at[4], 64'd7);
    chk("t3_rd_en", m_rd_en, 64'hA02);
    chk("t3_rvalid", m_rvalid, 64'h2808);
    chk("t3_rdata", {d_at[3], d_at[11], d_at[13]}, {16'hA006, 16'h1234, 16'hA008});
    chk("t3_terr", m_terr, 64'd0);
    chk("t3_done", m_done, 64'h2000);
    chk("t3_rid", rid_at[13], 64'd1);

    // sensor timeout, then a new grant clears TERR
    do_reset();
    sens_dly = 0; tval = 16'hBEEF;
    addr0 = 6'd7; len0 = 6'd1; req0 = 1'b1;
    addr1 = 6'd32; len1 = 6'd1;
    for (int c = 1; c <= 24; c++) begin
      tick(c);
      if (c == 20) req1 = 1'b1;
    end
    chk("t4_tstart", m_tstart, 64'h4);
    chk("t4_rd_en", m_rd_en, (64'd1 << 17) | (64'd1 << 21));
    chk("t4_terr", m_terr, 64'h1E0000);
    chk("t4_rvalid", m_rvalid, (64'd1 << 19) | (64'd1 << 23));
    chk("t4_rdata", d_at[19], 64'hBEEF);
    chk("t4_gnt1", m_gnt1, 64'd1 << 21);

    // address wrap, then a zero-length burst
    do_reset();
    addr0 = 6'd62; len0 = 6'd3; req0 = 1'b1;
    len1 = 6'd0; addr1 = 6'd5;
    for (int c = 1; c <= 12; c++) begin
      tick(c);
      if (c == 8) req1 = 1'b1;
    end
    chk("t5_a_seq", {a_at[1], a_at[3], a_at[5]}, {6'd62, 6'd63, 6'd0});
    chk("t5_rdata", {d_at[3], d_at[5], d_at[7]}, {16'hA03E, 16'hA03F, 16'hA000});
    chk("t5_rvalid", m_rvalid, 64'hA8);
    chk("t5_rd_en", m_rd_en, 64'h2A);
    chk("t5_gnt1", m_gnt1, 64'h200);
    chk("t5_done", m_done, 64'h480);
    chk("t5_busy", m_busy, 64'h27E);
    chk("t5_rid", rid_at[10], 64'd1);

    // reset in the middle of a burst
    do_reset();
    addr0 = 6'd16; len0 = 6'd5; req0 = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      tick(c);
      if (c == 5) rst = 1'b1;
      if (c == 6) begin
        chk("t6_outputs_zero",
            {gnt0, gnt1, a, rd_en, tstart, rdata, rvalid, rid, rlast, done, busy, terr}, 64'd0);
        rst = 1'b0;
      end
      if (c == 7) begin
        addr0 = 6'd1; len0 = 6'd1; addr1 = 6'd2; len1 = 6'd1;
        req0 = 1'b1; req1 = 1'b1;
      end
    end
    req1 = 1'b0;
    chk("t6_rvalid_before", m_rvalid[5:0], 64'h28);
    chk("t6_no_done", (m_done | m_rlast) & 64'h3FF, 64'd0);
    chk("t6_gnt0", m_gnt0, 64'h102);
    chk("t6_gnt1", m_gnt1, 64'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
